// File: rtl/sign_gen_pkg.sv
// Shared class codes, LFSR constants and output-state type for the
// class-directed signed sample generator.
package sign_gen_pkg;

  // Class codes are {positive_flag, negative_flag}.
  localparam logic [1:0] CLS_ZERO = 2'b00;
  localparam logic [1:0] CLS_NEG  = 2'b01;
  localparam logic [1:0] CLS_POS  = 2'b10;
  localparam logic [1:0] CLS_ILL  = 2'b11;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/sign_value_gen_lfsr16.sv
// 16-bit Galois LFSR magnitude source; advances one step when step is high.
module lfsr16
  import sign_gen_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  output logic [15:0] value
);

  // An all-zero state would lock the LFSR, so a zero seed becomes 1.
  localparam logic [15:0] RESET_VALUE = (SEED == 16'h0000) ? 16'h0001 : SEED;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= RESET_VALUE;
    end else if (step) begin
      value <= (value >> 1) ^ (value[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/sign_value_gen.sv
// Emits a WIDTH-bit two's-complement sample of the requested sign class
// through a one-entry registered output with per-class saturating counters.
module sign_value_gen
  import sign_gen_pkg::*;
#(
  parameter int          WIDTH = 16,
  parameter logic [15:0] SEED  = DEFAULT_SEED,
  parameter int          CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_pos,
  input  logic             req_neg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             err_illegal,
  output logic [CNT_W-1:0] pos_count,
  output logic [CNT_W-1:0] neg_count,
  output logic [CNT_W-1:0] zero_count
);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // req_ready depends only on the output register state and out_ready.

  out_state_t       state, state_next;
  logic [15:0]      lfsr_value;
  logic [1:0]       cls;
  logic             accept, legal_acc, load, lfsr_step;
  logic [WIDTH-2:0] mag;
  logic [WIDTH-1:0] sample;
  logic             unused_bits;

  assign cls       = {req_pos, req_neg};
  assign req_ready = (state == EMPTY) || out_ready;
  assign accept    = req_valid && req_ready;
  assign legal_acc = accept && (cls != CLS_ILL);
  assign lfsr_step = accept && ((cls == CLS_POS) || (cls == CLS_NEG));
  assign out_valid = (state == FULL);

  assign mag         = lfsr_value[WIDTH-2:0];
  assign unused_bits = ^lfsr_value[15:WIDTH-1];

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (lfsr_step),
    .value (lfsr_value)
  );

  always_comb begin
    sample = '0;
    case (cls)
      // A zero magnitude is not positive, so it is nudged to 1.
      CLS_POS: sample = (mag == '0) ? WIDTH'(1) : {1'b0, mag};
      CLS_NEG: sample = {1'b1, mag};
      default: sample = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      EMPTY: begin
        if (legal_acc) begin
          state_next = FULL;
          load       = 1'b1;
        end
      end
      FULL: begin
        if (legal_acc) begin
          load = 1'b1;
        end else if (out_ready) begin
          state_next = EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= EMPTY;
      out_data    <= '0;
      err_illegal <= 1'b0;
    end else begin
      state <= state_next;
      if (load) begin
        out_data <= sample;
      end
      if (accept && (cls == CLS_ILL)) begin
        err_illegal <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_count  <= '0;
      neg_count  <= '0;
      zero_count <= '0;
    end else if (legal_acc) begin
      if (cls == CLS_POS && pos_count != '1) pos_count <= pos_count + CNT_W'(1);
      if (cls == CLS_NEG && neg_count != '1) neg_count <= neg_count + CNT_W'(1);
      if (cls == CLS_ZERO && zero_count != '1) zero_count <= zero_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sign_value_gen.sv
// Bench for sign_value_gen: directed vector table, hand-written corner
// sequences and a random phase checked against a reference model.
module tb_sign_value_gen;
  localparam int W = 16;

  logic          clk, rst;
  logic          req_valid, req_pos, req_neg, out_ready;
  logic          req_ready, out_valid, err_illegal;
  logic [W-1:0]  out_data;
  logic [15:0]   pos_count, neg_count, zero_count;
  logic          d4_req_ready, d4_out_valid, d4_err;
  logic [W-1:0]  d4_out_data;
  logic [3:0]    d4_pos, d4_neg, d4_zero;

  sign_value_gen dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_pos(req_pos), .req_neg(req_neg), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .err_illegal(err_illegal),
    .pos_count(pos_count), .neg_count(neg_count), .zero_count(zero_count)
  );

  sign_value_gen #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(d4_req_ready),
    .req_pos(req_pos), .req_neg(req_neg), .out_valid(d4_out_valid),
    .out_ready(out_ready), .out_data(d4_out_data), .err_illegal(d4_err),
    .pos_count(d4_pos), .neg_count(d4_neg), .zero_count(d4_zero)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model + scoreboard ----------------
  int            n_pass = 0;
  int            n_total = 0;
  logic [15:0]   m_lfsr;
  logic          m_full, m_err;
  int            m_pos, m_neg, m_zero;
  logic [W-1:0]  exp_q[$];
  logic [1:0]    cls_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  function automatic logic [W-1:0] model_sample(input logic [1:0] c, input logic [15:0] l);
    logic [W-1:0] v;
    v = '0;
    if (c == 2'b10) begin
      v = {1'b0, l[14:0]};
      if (v == '0) v = 16'h0001;
    end else if (c == 2'b01) begin
      v = {1'b1, l[14:0]};
    end
    return v;
  endfunction

  function automatic int sat15(input int x);
    return (x > 15) ? 15 : x;
  endfunction

  // Asserts reset at the current (negedge) point and checks the async clear.
  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0; req_pos = 1'b0; req_neg = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", {16'b0, out_data}, 32'd0);
    check("rst_err", {31'b0, err_illegal}, 32'd0);
    check("rst_counts", {pos_count, neg_count | zero_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_lfsr = 16'hACE1; m_full = 1'b0; m_err = 1'b0;
    m_pos = 0; m_neg = 0; m_zero = 0;
    exp_q.delete(); cls_q.delete();
  endtask

  // One clock of stimulus; entered and left at a falling edge.
  task automatic step_cycle(input logic v, input logic p, input logic n, input logic r);
    logic         acc;
    logic [1:0]   c, got_cls, want_cls;
    logic [W-1:0] want;
    req_valid = v; req_pos = p; req_neg = n; out_ready = r;
    c = {p, n};
    #1;
    check("req_ready", {31'b0, req_ready}, {31'b0, (!m_full || r)});
    acc = v && (!m_full || r);
    if (m_full && r) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        want = exp_q.pop_front();
        want_cls = cls_q.pop_front();
        check("sb_out_data", {16'b0, out_data}, {16'b0, want});
        got_cls = {(!out_data[W-1] && out_data != '0), out_data[W-1]};
        check("sb_class", {30'b0, got_cls}, {30'b0, want_cls});
      end
    end
    if (acc && c == 2'b11) m_err = 1'b1;
    if (acc && c != 2'b11) begin
      exp_q.push_back(model_sample(c, m_lfsr));
      cls_q.push_back(c);
      if (c == 2'b10) m_pos++;
      if (c == 2'b01) m_neg++;
      if (c == 2'b00) m_zero++;
      if (c != 2'b00) m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
      m_full = 1'b1;
    end else if (m_full && r) begin
      m_full = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check("out_valid", {31'b0, out_valid}, {31'b0, m_full});
    check("err_illegal", {31'b0, err_illegal}, {31'b0, m_err});
    check("pos_count", {16'b0, pos_count}, m_pos);
    check("neg_count", {16'b0, neg_count}, m_neg);
    check("zero_count", {16'b0, zero_count}, m_zero);
    check("pos_count_w4", {28'b0, d4_pos}, sat15(m_pos));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        v, p, n, r;
    logic        exp_valid;
    logic [15:0] exp_data;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [W-1:0] held;
    logic [1:0]   c;
    int           k;

    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h2CE1};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h6270};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'hF138};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'hB89C};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'hB89C};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000};

    rst = 1'b1;
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 8; i++) begin
      step_cycle(tbl[i].v, tbl[i].p, tbl[i].n, tbl[i].r);
      check($sformatf("tbl%0d_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].exp_valid});
      if (tbl[i].exp_valid)
        check($sformatf("tbl%0d_data", i), {16'b0, out_data}, {16'b0, tbl[i].exp_data});
    end
    check("illegal_sets_err", {31'b0, err_illegal}, 32'd1);

    // Sticky error survives further legal traffic.
    for (int i = 0; i < 10; i++) step_cycle(1'b1, i[0], !i[0], 1'b1);
    check("err_still_set", {31'b0, err_illegal}, 32'd1);

    // Negative then zero: zero must not advance the LFSR.
    do_reset();
    step_cycle(1'b1, 1'b0, 1'b1, 1'b1);
    check("neg_first", {16'b0, out_data}, 32'h0000ACE1);
    step_cycle(1'b1, 1'b0, 1'b0, 1'b1);
    check("zero_sample", {16'b0, out_data}, 32'd0);
    step_cycle(1'b1, 1'b1, 1'b0, 1'b1);
    check("pos_after_zero", {16'b0, out_data}, 32'h00006270);

    // Illegal request from EMPTY: no output, counters untouched.
    do_reset();
    step_cycle(1'b1, 1'b1, 1'b1, 1'b1);
    check("ill_no_valid", {31'b0, out_valid}, 32'd0);
    check("ill_no_count", {pos_count, neg_count | zero_count}, 32'd0);

    // Backpressure: held sample stays stable, then back-to-back replace.
    do_reset();
    step_cycle(1'b1, 1'b1, 1'b0, 1'b1);
    held = out_data;
    check("bp_load", {16'b0, held}, 32'h00002CE1);
    for (int i = 0; i < 5; i++) begin
      step_cycle(1'b1, 1'b0, 1'b1, 1'b0);
      check("bp_stable", {16'b0, out_data}, {16'b0, held});
    end
    step_cycle(1'b1, 1'b1, 1'b1, 1'b0);
    check("bp_ill_blocked", {31'b0, err_illegal}, 32'd0);
    step_cycle(1'b1, 1'b0, 1'b1, 1'b1);
    check("bp_replace", {16'b0, out_data}, 32'h0000E270);
    check("bp_no_bubble", {31'b0, out_valid}, 32'd1);

    // Reset while FULL drops the pending sample immediately.
    do_reset();
    step_cycle(1'b1, 1'b1, 1'b0, 1'b0);
    step_cycle(1'b1, 1'b0, 1'b1, 1'b0);
    do_reset();
    step_cycle(1'b1, 1'b1, 1'b0, 1'b1);
    check("post_rst_pos", {16'b0, out_data}, 32'h00002CE1);

    // Saturation of the narrow counter instance.
    do_reset();
    for (int i = 0; i < 20; i++) step_cycle(1'b1, 1'b1, 1'b0, 1'b1);
    check("sat_w4", {28'b0, d4_pos}, 32'd15);
    check("nosat_w16", {16'b0, pos_count}, 32'd20);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 9);
      c = (k < 3) ? 2'b10 : (k < 6) ? 2'b01 : (k < 9) ? 2'b00 : 2'b11;
      step_cycle($urandom_range(0, 3) != 0, c[1], c[0], $urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
